// File: rtl/fdd_port_ctrl.sv
// Floppy port controller between the CPU bus and the wd1793: CPU hold with timeout,
// N-drive/side select, per-drive image-ready flags, motor retrigger timer and status readback.
module fdd_port_ctrl #(
  parameter int unsigned DRIVES       = 2,
  parameter int unsigned HOLD_TIMEOUT = 200000,
  parameter int unsigned ARM_TICKS    = 2,
  parameter int unsigned MOTOR_TICKS  = 4000000,
  parameter bit          MOTOR_GATE   = 1'b0,
  localparam int unsigned DSEL_W      = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              io_sel,
  input  logic              io_wr,
  input  logic [1:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              fdc_drq,
  input  logic              fdc_busy,
  input  logic              fdc_intrq,
  input  logic [DRIVES-1:0] img_mounted,
  output logic              cpu_hold,
  output logic [DSEL_W-1:0] drive_sel,
  output logic              side,
  output logic              ready,
  output logic              motor_on,
  output logic [DRIVES-1:0] ready_mask
);

  localparam int unsigned ARM_W = (ARM_TICKS > 0) ? $clog2(ARM_TICKS + 1) : 1;
  localparam int unsigned TO_W  = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam int unsigned MOT_W = (MOTOR_TICKS > 0) ? $clog2(MOTOR_TICKS + 1) : 1;

  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_TICKS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HOLD_TIMEOUT - 1);
  localparam logic [MOT_W-1:0] MOT_LOAD = MOT_W'(MOTOR_TICKS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_flag_q, timeout_flag_d;
  logic              side_q, side_d;
  logic [DSEL_W-1:0] drive_sel_q, drive_sel_d;
  logic [MOT_W-1:0]  motor_cnt_q, motor_cnt_d;
  logic              wr_prev_q;
  logic [DRIVES-1:0] mnt_prev_q;
  logic [DRIVES-1:0] ready_mask_q, ready_mask_d;

  logic wr_lvl, wr_ev, wr0, wr1, wr2, wr3, rd0, timeout_hit;

  assign wr_lvl = io_sel & io_wr;
  assign wr_ev  = wr_lvl & ~wr_prev_q;
  assign wr0    = wr_ev & (addr == 2'd0);
  assign wr1    = wr_ev & (addr == 2'd1);
  assign wr2    = wr_ev & (addr == 2'd2);
  assign wr3    = wr_ev & (addr == 2'd3);
  assign rd0    = io_sel & ~io_wr & (addr == 2'd0);

  assign timeout_hit = ce && (HOLD_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  // A re-arm write outranks every release; a normal release outranks the timeout.
  always_comb begin
    state_d        = state_q;
    arm_cnt_d      = arm_cnt_q;
    to_cnt_d       = to_cnt_q;
    timeout_flag_d = timeout_flag_q & ~rd0;
    if (wr0) begin
      state_d   = (ARM_TICKS == 0) ? ST_HOLD : ST_ARM;
      arm_cnt_d = ARM_LOAD;
      to_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (fdc_drq || fdc_intrq) begin
            state_d = ST_IDLE;
          end else if (timeout_hit) begin
            state_d        = ST_IDLE;
            timeout_flag_d = 1'b1;
          end else if (ce) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            arm_cnt_d = arm_cnt_q - ARM_W'(1);
            if (arm_cnt_q <= ARM_W'(1)) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (fdc_drq || !fdc_busy || fdc_intrq) begin
            state_d = ST_IDLE;
          end else if (timeout_hit) begin
            state_d        = ST_IDLE;
            timeout_flag_d = 1'b1;
          end else if (ce) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    cpu_hold_d = (state_d != ST_IDLE);
  end

  always_comb begin
    side_d      = wr2 ? din[0] : side_q;
    drive_sel_d = drive_sel_q;
    if (wr3 && (32'(din) < DRIVES)) drive_sel_d = din[DSEL_W-1:0];
    motor_cnt_d = motor_cnt_q;
    if (wr0 || wr1 || wr3 || fdc_busy) motor_cnt_d = MOT_LOAD;
    else if (ce && (motor_cnt_q != '0)) motor_cnt_d = motor_cnt_q - MOT_W'(1);
    ready_mask_d = ready_mask_q | (img_mounted & ~mnt_prev_q);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cpu_hold_q     <= 1'b0;
      arm_cnt_q      <= '0;
      to_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
      side_q         <= 1'b0;
      drive_sel_q    <= '0;
      motor_cnt_q    <= '0;
      wr_prev_q      <= 1'b0;
      mnt_prev_q     <= '0;
    end else begin
      state_q        <= state_d;
      cpu_hold_q     <= cpu_hold_d;
      arm_cnt_q      <= arm_cnt_d;
      to_cnt_q       <= to_cnt_d;
      timeout_flag_q <= timeout_flag_d;
      side_q         <= side_d;
      drive_sel_q    <= drive_sel_d;
      motor_cnt_q    <= motor_cnt_d;
      wr_prev_q      <= wr_lvl;
      mnt_prev_q     <= img_mounted;
    end
  end

  // Mounted images survive reset.
  always_ff @(posedge clk_sys) begin
    ready_mask_q <= ready_mask_d;
  end

  assign cpu_hold   = cpu_hold_q;
  assign drive_sel  = drive_sel_q;
  assign side       = side_q;
  assign motor_on   = (motor_cnt_q != '0);
  assign ready_mask = ready_mask_q;
  assign ready      = ready_mask_q[drive_sel_q] & (MOTOR_GATE ? motor_on : 1'b1);

  always_comb begin
    case (addr)
      2'd0:    dout = {fdc_busy, fdc_drq, fdc_intrq, ready, motor_on,
                       timeout_flag_q, cpu_hold_q, side_q};
      2'd1:    dout = 8'(ready_mask_q);
      2'd2:    dout = {7'b0, side_q};
      default: dout = 8'(drive_sel_q);
    endcase
  end

endmodule

// File: doc/fdd_port_ctrl.md
Name: fdd_port_ctrl

Overview:
Parametrised successor to the single-drive floppy latch that sits at the FFF0-FFF3 decode of the MX machine. It sits between the CPU bus and the wd1793 controller. It holds the CPU until the FDC raises DRQ or finishes, and this hold now has a timeout. It also provides N-drive select, side select, per-drive image-ready tracking, a motor-on retrigger timer, and a readable status register.

Parameters:
DRIVES, 2, number of drives (1..8); DSEL_W = max(1, clog2(DRIVES)).
HOLD_TIMEOUT, 200000, ce ticks before a forced hold release (0 = no timeout).
ARM_TICKS, 2, ce ticks after arming during which ~fdc_busy is ignored as a release condition.
MOTOR_TICKS, 4000000, ce ticks the motor stays on after the last retrigger.
MOTOR_GATE, 0, 1 = ready output is ANDed with motor_on.

Ports:
clk_sys  in  1  system clock (96 MHz)
reset  in  1  synchronous, active-high
ce  in  1  CPU-rate clock enable; all tick counters advance only on ce
io_sel  in  1  block address-decode select
io_wr  in  1  write strobe level (qualified with io_sel internally)
addr  in  2  register index
din  in  8  write data
dout  out  8  read data (combinational)
fdc_drq  in  1  FDC data request
fdc_busy  in  1  FDC busy
fdc_intrq  in  1  FDC interrupt request
img_mounted  in  DRIVES  per-drive mount pulse
cpu_hold  out  1  CPU hold request
drive_sel  out  DSEL_W  selected drive index
side  out  1  head side
ready  out  1  ready for the selected drive, to FDC
motor_on  out  1  motor active
ready_mask  out  DRIVES  per-drive image-ready flags

Behaviour:
- Clock and reset: clock is clk_sys; reset is reset, synchronous, active-high.
- Write event: rising edge of (io_sel & io_wr), detected with a registered previous value. Exactly one event fires per strobe, however long it is held. Writes act on the cycle after the edge.
- Register map, writes:
  - 0: arm hold.
  - 1: retrigger motor; din is ignored.
  - 2: side <= din[0].
  - 3: drive_sel <= din[DSEL_W-1:0] if the value < DRIVES, else ignored.
- Register map, reads:
  - 0: {fdc_busy, fdc_drq, fdc_intrq, ready, motor_on, timeout_flag, cpu_hold, side}.
  - 1: ready_mask zero-extended to 8 bits.
  - 2: {7'b0, side}.
  - 3: drive_sel zero-extended.
- Reading address 0 while io_sel is high clears timeout_flag on the next cycle.
- Hold FSM states: IDLE, ARM, HOLD.
  - IDLE: on a write to addr 0, set cpu_hold=1, load arm_cnt=ARM_TICKS, clear to_cnt, go to ARM.
  - ARM: decrement arm_cnt per ce. If fdc_drq or fdc_intrq, release. Else when arm_cnt reaches 0, go to HOLD.
  - HOLD: release when fdc_drq | ~fdc_busy | fdc_intrq.
  - ARM and HOLD: to_cnt increments per ce. When to_cnt == HOLD_TIMEOUT-1 (HOLD_TIMEOUT≠0), force release and set timeout_flag=1.
  - Release: cpu_hold=0, return to IDLE in the same cycle.
  - A write to addr 0 while already in ARM/HOLD re-arms: arm_cnt and to_cnt are reloaded and the state goes to ARM.
- Motor:
  - motor_cnt is loaded with MOTOR_TICKS on any of: write to addr 0/1/3, or fdc_busy=1 in any cycle.
  - Otherwise motor_cnt decrements per ce down to 0 and saturates.
  - motor_on = (motor_cnt≠0).
- Ready tracking:
  - ready_mask[i] is set on the rising edge of img_mounted[i].
  - ready = ready_mask[drive_sel] & (MOTOR_GATE ? motor_on : 1).
- Reset:
  - cpu_hold=0, state=IDLE, side=0, drive_sel=0, timeout_flag=0, motor_cnt=0, edge detectors cleared.
  - ready_mask is NOT cleared by reset; the image stays mounted. Its power-up value is 0.
- Simultaneous events:
  - If a release condition and a re-arm write land in the same cycle, the write wins.
  - If the timeout and fdc_drq land in the same cycle, it is a normal release and timeout_flag is not set.
- Reset mid-hold: cpu_hold drops on the cycle after reset is sampled.

Test Plan:
- Write 0 to addr 0 with fdc_busy=1 → cpu_hold=1 next cycle. Pulse fdc_drq → cpu_hold=0 the cycle after; status bit1=0.
- Arm with fdc_busy=0 and ARM_TICKS=2 → hold persists for 2 ce ticks, then releases on ~busy. With fdc_drq=1 during ARM → immediate release.
- HOLD_TIMEOUT=16, fdc_busy stuck 1, no drq → cpu_hold drops after 16 ce ticks. Read addr 0 → bit2=1; a second read → bit2=0.
- DRIVES=4: pulse img_mounted[2]; write 2 to addr 3 → ready=1, addr1 reads 8'h04. Write 5 to addr 3 → drive_sel stays 2. Assert reset → drive_sel=0, ready_mask still 4'b0100.
- MOTOR_TICKS=10, MOTOR_GATE=1: write addr 1 → motor_on=1 and ready follows mask for 10 ce ticks, then motor_on=0, ready=0. fdc_busy=1 retriggers the timer.
- Hold io_sel&io_wr high for 5 cycles at addr 2 with din=1 → single event, side=1. Reset during HOLD → cpu_hold=0, state IDLE.
